mult_arb: RTL
=============

// Module: mult_arb
// PURPOSE
//   Shared-multiplier arbiter. Acts as responder to up to N_REQ initiators (svf, envelope, mixer
//   gain) using the mult start/ready/product handshake. Acts as the single initiator of the one
//   `mult` instance. Serialises requests round-robin so all DSP stages share one multiplier.
// PARAMETERS
//   N_REQ  3   number of requesting clients
//   A_W    24  operand A width (signed)
//   B_W    16  operand B width (signed)
//   P_W    40  product width, = A_W + B_W
// PORTS
//   clk_i         in   1            system clock
//   rst_ni        in   1            async active-low reset
//   start_i       in   N_REQ        per-client start; sampled only while that client's ready_o=1
//   op_a_i        in   N_REQ*A_W    per-client operand A; valid in the start_i cycle
//   op_b_i        in   N_REQ*B_W    per-client operand B; valid in the start_i cycle
//   ready_o       out  N_REQ        per-client idle/result-valid
//   prod_o        out  N_REQ*P_W    per-client product register
//   mult_start_o  out  1            start pulse to mult
//   mult_a_o      out  A_W          operand A to mult
//   mult_b_o      out  B_W          operand B to mult
//   mult_ready_i  in   1            mult idle / result valid; drops the cycle after mult_start_o
//   mult_prod_i   in   P_W          mult product; valid while mult_ready_i=1 after an operation
// BEHAVIOUR
//   Reset values
//   - ready_o = all 1s; prod_o = 0; mult_start_o = 0; mult_a_o = 0; mult_b_o = 0.
//   - All pending flags are cleared; the RR pointer is set to client 0; FSM is in IDLE.
//   Client side
//   - When start_i[i]=1 and ready_o[i]=1, capture op_a_i[i] and op_b_i[i] into the slot and set pend[i].
//   - ready_o[i]=0 from the next cycle.
//   - start_i[i] while ready_o[i]=0 is ignored.
//   - ready_o[i] returns to 1 in the same cycle prod_o[i] takes the new result.
//   - prod_o[i] holds until client i's next completed operation.
//   FSM (IDLE, ISSUE, BUSY)
//   - IDLE: if any pend bit is set and mult_ready_i=1:
//       grant = first pending client at or after rr_ptr (wrap-around);
//       load mult_a_o and mult_b_o from that slot; go to ISSUE.
//   - ISSUE: mult_start_o=1 for exactly one cycle; go to BUSY.
//   - BUSY: wait for mult_ready_i=1, then:
//       prod_o[grant] <= mult_prod_i; clear pend[grant];
//       rr_ptr <= grant+1 (mod N_REQ); go to IDLE.
//   - Operands on mult_a_o and mult_b_o are held stable from ISSUE through BUSY.
//   Timing
//   - Uncontended latency from start_i to ready_o[i]=1 is T_mult + 3 cycles.
//   - A client may re-issue in the cycle its ready_o[i] rises.
//   - The IDLE check uses the registered pend, so a start and a grant never occur in the same cycle.
//   Boundary conditions
//   - Simultaneous starts from all clients: all are captured; service order is rr_ptr first, then ascending with wrap.
//   - No client waits more than N_REQ-1 operations.
//   - A new start from a completed client while others are pending queues behind them (fairness).
//   - Async reset mid-operation aborts the operation: the result is discarded and the outputs return to reset values.
//   - mult shares rst_ni, so no stale product is captured.
//   - mult_ready_i=0 in IDLE (foreign reset skew) blocks the grant; no start is issued.
//   Arithmetic
//   - Pure pass-through, no truncation.
//   - Operand signedness is the client's concern; the arbiter does not sign-extend.
// STRUCTURE
//   - mult_pkg: MULT_A_W, MULT_B_W, MULT_P_W constants, shared by svf/mult/mult_arb.
//   - mult_pkg: arb_state_e enum {IDLE, ISSUE, BUSY}.
//   - Sub-module rr_arbiter: pend[N_REQ] and rr_ptr in, one-hot grant plus index out.
//   - rr_arbiter is combinational; the pointer register is kept in mult_arb.
// TESTING (mult_arb + mult + scoreboard)
//   - Single client: client 0, A=24'h000100, B=16'h0200.
//       Required: prod_o[0]=40'h0000020000; ready_o[0] low for exactly T_mult+3 cycles.
//   - Signed: client 1, A=-3 (24'hFFFFFD), B=7.
//       Required: prod_o[1]=-21 (40'hFFFFFFFFEB); prod_o[0] and prod_o[2] unchanged.
//   - All three clients start in the same cycle with rr_ptr=0, operands (1,2), (3,4), (5,6).
//       Required: completion order 0,1,2; products 2, 12, 30; exactly 3 mult_start_o pulses.
//   - Fairness: client 0 re-issues immediately after each completion while clients 1 and 2 are pending.
//       Required: grant sequence 0,1,2,0, never 0,0.
//   - Ignored start: pulse start_i[2] while ready_o[2]=0 with different operands.
//       Required: the original product is returned and only one operation is issued.
//   - Reset: drop rst_ni during BUSY.
//       Required: next cycle ready_o=3'b111, prod_o=0, mult_start_o=0.
//       Required: after release, a new request completes correctly.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared multiplier constants and arbiter state encoding, used by every
// block that talks to the single mult instance.
package mult_pkg;

  localparam int MULT_A_W = 24;
  localparam int MULT_B_W = 16;
  localparam int MULT_P_W = MULT_A_W + MULT_B_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

  // Index arithmetic modulo n; both arguments are assumed to be below n.
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) begin
      sum = sum - n;
    end else begin
      sum = sum;
    end
    return sum;
  endfunction

endpackage

// File: rtl/mult_arb_rr_arbiter.sv
// Combinational round-robin pick: first pending client at or after rr_ptr,
// wrapping around. The pointer register itself lives in the parent.
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand_s;

  // Scan clients starting at the pointer and stop at the first pending one.
  always_comb begin
    grant_oh  = {N_REQ{1'b0}};
    grant_idx = {IDX_W{1'b0}};
    any       = 1'b0;
    cand_s    = {IDX_W{1'b0}};
    for (int off = 0; off < N_REQ; off++) begin
      cand_s = IDX_W'(wrap_add(int'(rr_ptr), off, N_REQ));
      if (!any && pend[cand_s]) begin
        any               = 1'b1;
        grant_idx         = cand_s;
        grant_oh[cand_s]  = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/mult_arb.sv
// Shared-multiplier arbiter: captures per-client operand slots, serialises
// them round-robin onto one mult instance and returns each product to the
// client that asked for it.
module mult_arb
  import mult_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int A_W   = MULT_A_W,
  parameter int B_W   = MULT_B_W,
  parameter int P_W   = MULT_P_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]     start_i,
  input  logic [N_REQ*A_W-1:0] op_a_i,
  input  logic [N_REQ*B_W-1:0] op_b_i,
  output logic [N_REQ-1:0]     ready_o,
  output logic [N_REQ*P_W-1:0] prod_o,
  output logic               mult_start_o,
  output logic [A_W-1:0]     mult_a_o,
  output logic [B_W-1:0]     mult_b_o,
  input  logic               mult_ready_i,
  input  logic [P_W-1:0]     mult_prod_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state_r;
  logic [N_REQ-1:0] pend_r;
  logic [N_REQ-1:0] ready_r;
  logic [P_W-1:0]   prod_r   [N_REQ];
  logic [A_W-1:0]   slot_a_r [N_REQ];
  logic [B_W-1:0]   slot_b_r [N_REQ];
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] grant_idx_r;
  logic [N_REQ-1:0] grant_oh_r;
  logic             mult_start_r;
  logic [A_W-1:0]   mult_a_r;
  logic [B_W-1:0]   mult_b_r;

  logic [N_REQ-1:0] grant_oh_s;
  logic [IDX_W-1:0] grant_idx_s;
  logic             any_s;
  logic             done_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .pend      (pend_r),
    .rr_ptr    (rr_ptr_r),
    .grant_oh  (grant_oh_s),
    .grant_idx (grant_idx_s),
    .any       (any_s)
  );

  // The granted operation finishes when mult reports ready while we wait in BUSY.
  always_comb begin
    done_s = 1'b0;
    if ((state_r == BUSY) && mult_ready_i) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // Operand slots are written only on an accepted start, so later starts while busy cannot disturb them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_REQ; i++) begin
        slot_a_r[i] <= {A_W{1'b0}};
        slot_b_r[i] <= {B_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (start_i[i] && ready_r[i]) begin
          slot_a_r[i] <= op_a_i[i*A_W +: A_W];
          slot_b_r[i] <= op_b_i[i*B_W +: B_W];
        end else begin
          slot_a_r[i] <= slot_a_r[i];
          slot_b_r[i] <= slot_b_r[i];
        end
      end
    end
  end

  // Client bookkeeping plus the IDLE/ISSUE/BUSY sequencer driving the mult port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      pend_r       <= {N_REQ{1'b0}};
      ready_r      <= {N_REQ{1'b1}};
      rr_ptr_r     <= {IDX_W{1'b0}};
      grant_idx_r  <= {IDX_W{1'b0}};
      grant_oh_r   <= {N_REQ{1'b0}};
      mult_start_r <= 1'b0;
      mult_a_r     <= {A_W{1'b0}};
      mult_b_r     <= {B_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
        prod_r[i] <= {P_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (done_s && grant_oh_r[i]) begin
          prod_r[i]  <= mult_prod_i;
          pend_r[i]  <= 1'b0;
          ready_r[i] <= 1'b1;
        end else if (start_i[i] && ready_r[i]) begin
          pend_r[i]  <= 1'b1;
          ready_r[i] <= 1'b0;
        end else begin
          pend_r[i]  <= pend_r[i];
          ready_r[i] <= ready_r[i];
        end
      end

      case (state_r)
        IDLE: begin
          if (any_s && mult_ready_i) begin
            grant_idx_r  <= grant_idx_s;
            grant_oh_r   <= grant_oh_s;
            mult_a_r     <= slot_a_r[grant_idx_s];
            mult_b_r     <= slot_b_r[grant_idx_s];
            mult_start_r <= 1'b1;
            state_r      <= ISSUE;
          end else begin
            mult_start_r <= 1'b0;
            state_r      <= IDLE;
          end
        end
        ISSUE: begin
          mult_start_r <= 1'b0;
          state_r      <= BUSY;
        end
        BUSY: begin
          if (mult_ready_i) begin
            rr_ptr_r   <= IDX_W'(wrap_add(int'(grant_idx_r), 1, N_REQ));
            grant_oh_r <= {N_REQ{1'b0}};
            state_r    <= IDLE;
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          mult_start_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign ready_o      = ready_r;
  assign mult_start_o = mult_start_r;
  assign mult_a_o     = mult_a_r;
  assign mult_b_o     = mult_b_r;

  for (genvar g = 0; g < N_REQ; g++) begin : g_prod
    assign prod_o[g*P_W +: P_W] = prod_r[g];
  end

endmodule
